// File: rtl/mul_ctrl_pkg.sv
// Shared M-extension definitions: op encodings, controller states, iteration count.
package mul_ctrl_pkg;

    localparam int MUL_ITER = 32;

    typedef enum logic [1:0] {
        MUL_OP    = 2'b00,
        MULH_OP   = 2'b01,
        MULHSU_OP = 2'b10,
        MULHU_OP  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BUSY,
        DONE,
        DRAIN
    } mul_state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic s);
        return s ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mul_ctrl_multiplier.sv
// Unsigned 32x32 shift-add multiplier, one partial product per cycle.
// stallreq is high while iterating; result is valid once it drops.
module multiplier
    import mul_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stallreq,
    output logic [31:0] result_h,
    output logic [31:0] result_l
);

    logic [63:0] prod_q;
    logic [31:0] mcand_q;
    logic [5:0]  cnt_q;
    logic        run_q;
    logic [32:0] sum;

    // Add multiplicand into the high half when the current multiplier bit is set.
    always_comb begin
        sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    end

    // Load on in_valid, then shift-add until the iteration count expires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (in_valid) begin
            prod_q  <= {32'd0, b};
            mcand_q <= a;
            cnt_q   <= 6'(MUL_ITER);
            run_q   <= 1'b1;
        end else if (run_q) begin
            prod_q <= {sum, prod_q[31:1]};
            cnt_q  <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) run_q <= 1'b0;
        end
    end

    assign stallreq = run_q;
    assign result_h = prod_q[63:32];
    assign result_l = prod_q[31:0];

endmodule

// File: rtl/mul_ctrl.sv
// M-extension multiply sequencer: sign handling around the unsigned
// multiplier, result selection, and a one-entry product reuse buffer.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int TAG_W    = 5,
    parameter int REUSE_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    mul_state_e       state_q, state_d;
    mul_op_e          op_q, buf_op_q;
    logic [TAG_W-1:0] tag_q, resp_tag_q;
    logic [31:0]      a_q, b_q, resp_data_q;
    logic             sa_q, sb_q;
    logic             buf_vld_q;
    logic [31:0]      buf_a_q, buf_b_q;
    logic [63:0]      buf_p_q;

    logic        accept, hit, complete, abort;
    logic        sa_in, sb_in;
    logic        m_stall;
    logic [31:0] m_res_h, m_res_l;
    logic [63:0] prod, p_corr;
    logic [31:0] sel_word, hit_word;

    assign req_ready = (state_q == IDLE) & ~flush;
    assign accept    = req_valid & req_ready;
    assign sa_in     = (req_op != MULHU_OP) & req_a[31];
    assign sb_in     = ((req_op == MUL_OP) | (req_op == MULH_OP)) & req_b[31];
    assign complete  = (state_q == BUSY) & ~flush & ~m_stall;
    assign abort     = flush & ((state_q == START) | (state_q == BUSY));

    // Reuse lookup; a MUL hits on any stored op since the low word ignores signedness.
    always_comb begin
        hit = (REUSE_EN != 0) & buf_vld_q & (req_a == buf_a_q) & (req_b == buf_b_q) &
              ((req_op == buf_op_q) | (req_op == MUL_OP));
        hit_word = (req_op == MUL_OP) ? buf_p_q[31:0] : buf_p_q[63:32];
    end

    // Sign-correct the raw product and pick the word the op asks for.
    always_comb begin
        prod     = {m_res_h, m_res_l};
        p_corr   = (sa_q ^ sb_q) ? (~prod + 64'd1) : prod;
        sel_word = (op_q == MUL_OP) ? p_corr[31:0] : p_corr[63:32];
    end

    multiplier u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (state_q == START),
        .a        (mag32(a_q, sa_q)),
        .b        (mag32(b_q, sb_q)),
        .stallreq (m_stall),
        .result_h (m_res_h),
        .result_l (m_res_l)
    );

    // Next-state logic; flush wins over every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = hit ? DONE : START;
            START:   state_d = flush ? DRAIN : BUSY;
            BUSY:    if (flush) state_d = DRAIN;
                     else if (!m_stall) state_d = DONE;
            DONE:    if (flush || resp_ready) state_d = IDLE;
            DRAIN:   if (!m_stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request capture, response registers and reuse buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= MUL_OP;
            tag_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
            buf_vld_q   <= 1'b0;
            buf_a_q     <= '0;
            buf_b_q     <= '0;
            buf_op_q    <= MUL_OP;
            buf_p_q     <= '0;
        end else begin
            if (accept) begin
                op_q  <= mul_op_e'(req_op);
                tag_q <= req_tag;
                a_q   <= req_a;
                b_q   <= req_b;
                sa_q  <= sa_in;
                sb_q  <= sb_in;
                if (hit) begin
                    resp_data_q <= hit_word;
                    resp_tag_q  <= req_tag;
                end
            end
            if (complete) begin
                resp_data_q <= sel_word;
                resp_tag_q  <= tag_q;
                buf_vld_q   <= 1'b1;
                buf_a_q     <= a_q;
                buf_b_q     <= b_q;
                buf_op_q    <= op_q;
                buf_p_q     <= p_corr;
            end
            if (abort) buf_vld_q <= 1'b0;
        end
    end

    assign resp_valid = (state_q == DONE);
    assign resp_data  = resp_data_q;
    assign resp_tag   = resp_tag_q;
    assign busy       = (state_q != IDLE);

endmodule
